ro_puf_challenge_ctrl: RTL
==========================

Name: ro_puf_challenge_ctrl

Overview:
Sequences the ring-oscillator PUF datapath for one challenge. Drives the two 4-bit RO select buses into the pair of 4-to-16 one-hot decoders and gates the RO enable. Times the counting window, clears and samples the two frequency counters, and compares their counts. Runs RESP_BITS evaluations per challenge and assembles them into a response word.

Parameters:
RESP_BITS, 8, number of RO-pair evaluations (response bits) per challenge; 1..16
WIN_CYC, 1024, counting window length in clk cycles; >=1
SETTLE_CYC, 4, cycles between RO disable and count sampling (counter/CDC settle); >=1
CNT_W, 16, width of the external RO counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
chal_a  in  4  base index of RO group A
chal_b  in  4  base index of RO group B
cnt_a  in  CNT_W  count from RO counter A
cnt_b  in  CNT_W  count from RO counter B
sel_a  out  4  select to decoder A
sel_b  out  4  select to decoder B
ro_en  out  1  gates the selected ROs
cnt_clr  out  1  synchronous clear to both RO counters
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the response is valid
err  out  1  challenge rejected (chal_a == chal_b)
resp  out  RESP_BITS  response word

Behaviour:
- Reset (asynchronous, immediate): state IDLE; sel_a=sel_b=0; ro_en=0; cnt_clr=0; busy=0; done=0; err=0; resp=0; all internal counters=0. Reset mid-evaluation drops ro_en in the same instant. No partial response is retained.
- States: IDLE, CLEAR, RUN, SETTLE, CMP, DONE.
- IDLE: on start=1, latch chal_a and chal_b, clear resp and err, set k=0, set busy=1.
  - If chal_a==chal_b: go to DONE with err=1 and resp=0. No RO activity.
  - Otherwise go to CLEAR.
  - start in any other state is ignored.
- CLEAR (1 cycle): sel_a=(chal_a+k) mod 16 and sel_b=(chal_b+k) mod 16, using 4-bit wrap-around. cnt_clr=1. Then go to RUN.
- RUN (WIN_CYC cycles): ro_en=1 and sel stable. Window counter counts 0..WIN_CYC-1, then go to SETTLE.
- SETTLE (SETTLE_CYC cycles): ro_en=0 and sel held. Then go to CMP.
- CMP (1 cycle): resp[k] = (cnt_a > cnt_b), unsigned. A tie gives 0.
  - If k==RESP_BITS-1, go to DONE.
  - Else k=k+1 and go to CLEAR.
- DONE (1 cycle): done=1. Next cycle: busy=0, go to IDLE.
- resp and err hold until the next accepted start.
- sel_a and sel_b hold their last value in IDLE.
- Latency for a valid challenge: done is high RESP_BITS*(WIN_CYC+SETTLE_CYC+2)+1 cycles after the start-sampling edge.
- Latency for a rejected challenge: done is high the cycle after acceptance.
- ro_en is never high in CLEAR, SETTLE, CMP, DONE or IDLE.
- sel changes only in CLEAR, so the decoders never switch while ro_en=1.
- Because chal_a != chal_b and both offsets use the same k, sel_a != sel_b in every evaluation.

Optional Feature:
Macro PUF_MAJ3_EN.
- Defined: each response bit is evaluated 3 times (CLEAR/RUN/SETTLE/CMP repeated with the same sel). The three compare results are stored, and resp[k] is their majority.
- Defined: latency becomes RESP_BITS*3*(WIN_CYC+SETTLE_CYC+2)+1.
- Undefined: single evaluation per bit, as above. No vote registers are present.

Test Plan:
- Bench params RESP_BITS=4, WIN_CYC=16, SETTLE_CYC=2. A behavioural counter model counts at a per-RO rate while ro_en=1.
- Scenario 1: chal_a=3, chal_b=9, RO rates such that A > B for pairs 0,2 and A < B for pairs 1,3 -> resp=4'b0101; done high exactly 81 cycles after start; sel sequence (3,9),(4,10),(5,11),(6,12).
- Scenario 2: chal_a=14, chal_b=1 -> sel_a sequence 14,15,0,1; sel_b sequence 1,2,3,4 (wrap checked).
- Scenario 3: chal_a=chal_b=7 -> err=1, resp=0, ro_en never high, done one cycle after the start edge.
- Scenario 4: equal counts on all pairs -> resp=0. Also: start pulses while busy -> ignored, resp unchanged by them.
- Scenario 5: rst_n low during RUN of bit 2 -> ro_en=0 and busy=0 immediately, resp=0. A new start after release completes normally with 81-cycle latency.
- Scenario 6 (PUF_MAJ3_EN): counter model gives A > B on 2 of 3 runs for bit 0 -> resp[0]=1; done at 241 cycles.

Source files
------------

// File: rtl/ro_puf_challenge_ctrl.sv
// ro_puf_challenge_ctrl: sequences RO-pair clear/run/settle/compare per response bit; PUF_MAJ3_EN adds a 3-run majority vote per bit
module ro_puf_challenge_ctrl #(
  parameter int RESP_BITS  = 8,
  parameter int WIN_CYC    = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           chal_a,
  input  logic [3:0]           chal_b,
  input  logic [CNT_W-1:0]     cnt_a,
  input  logic [CNT_W-1:0]     cnt_b,
  output logic [3:0]           sel_a,
  output logic [3:0]           sel_b,
  output logic                 ro_en,
  output logic                 cnt_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [RESP_BITS-1:0] resp
);
  localparam int KW = RESP_BITS > 1 ? $clog2(RESP_BITS) : 1;
  localparam int TW = $clog2((WIN_CYC > SETTLE_CYC ? WIN_CYC : SETTLE_CYC) + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, CMP, DONE} state_t;
  state_t state, state_n;
  logic [3:0] ca, cb, ca_n, cb_n, sel_a_n, sel_b_n;
  logic [KW-1:0] k, k_n;
  logic [TW-1:0] t, t_n;
  logic [RESP_BITS-1:0] resp_n;
  logic busy_n, err_n, gt, res_bit, last_k, fin;
`ifdef PUF_MAJ3_EN
  logic [1:0] r, r_n, v, v_n;
  assign fin = r == 2'd2;
  assign res_bit = (v[0] & v[1]) | (v[0] & gt) | (v[1] & gt);
`else
  assign fin = 1'b1;
  assign res_bit = gt;
`endif
  assign gt = cnt_a > cnt_b;
  assign last_k = k == KW'(RESP_BITS - 1);
  assign ro_en = state == RUN;
  assign cnt_clr = state == CLEAR;
  // next-state and next-value logic for the whole evaluation sequence
  always_comb begin
    state_n = state;
    ca_n = ca;
    cb_n = cb;
    k_n = k;
    t_n = t;
    resp_n = resp;
    err_n = err;
    busy_n = busy & ~done;
    sel_a_n = sel_a;
    sel_b_n = sel_b;
`ifdef PUF_MAJ3_EN
    r_n = r;
    v_n = v;
`endif
    case (state)
      IDLE: if (start && !busy) begin
        ca_n = chal_a;
        cb_n = chal_b;
        k_n = '0;
        resp_n = '0;
        err_n = chal_a == chal_b;
        busy_n = 1'b1;
        state_n = chal_a == chal_b ? DONE : CLEAR;
        sel_a_n = chal_a == chal_b ? sel_a : chal_a;
        sel_b_n = chal_a == chal_b ? sel_b : chal_b;
      end
      CLEAR: state_n = RUN;
      RUN: begin
        t_n = t == TW'(WIN_CYC - 1) ? '0 : t + TW'(1);
        state_n = t == TW'(WIN_CYC - 1) ? SETTLE : RUN;
      end
      SETTLE: begin
        t_n = t == TW'(SETTLE_CYC - 1) ? '0 : t + TW'(1);
        state_n = t == TW'(SETTLE_CYC - 1) ? CMP : SETTLE;
      end
      CMP: begin
        if (fin) resp_n[k] = res_bit;
        state_n = fin && last_k ? DONE : CLEAR;
        if (fin && !last_k) begin
          k_n = k + KW'(1);
          sel_a_n = ca + 4'(k) + 4'd1;
          sel_b_n = cb + 4'(k) + 4'd1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef PUF_MAJ3_EN
    if (state == CMP) begin
      r_n = fin ? 2'd0 : r + 2'd1;
      v_n[r[0]] = gt;
    end
`endif
  end
  // state and datapath registers; reset drops ro_en immediately through state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ca <= '0;
      cb <= '0;
      k <= '0;
      t <= '0;
      resp <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sel_a <= '0;
      sel_b <= '0;
`ifdef PUF_MAJ3_EN
      r <= '0;
      v <= '0;
`endif
    end else begin
      state <= state_n;
      ca <= ca_n;
      cb <= cb_n;
      k <= k_n;
      t <= t_n;
      resp <= resp_n;
      err <= err_n;
      busy <= busy_n;
      done <= state == DONE;
      sel_a <= sel_a_n;
      sel_b <= sel_b_n;
`ifdef PUF_MAJ3_EN
      r <= r_n;
      v <= v_n;
`endif
    end
endmodule
